// File: rtl/clm_state_decoder.sv
// Serial CLM decoder: captures one encoded state, then strips the r*B mask
// from one word per cycle and presents the plain state with a valid/ready handshake.
module clm_state_decoder #(
   parameter int d       = 4,
   parameter int N_WORDS = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [N_WORDS-1:0][8+d-1:0]    in_state,
   input  logic [d-1:0][7:0]              B,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [N_WORDS-1:0][7:0]        out_data,
   output logic                           err
);

   localparam int CW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
   localparam logic [CW-1:0] LAST = CW'(N_WORDS - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                         state, nxt;
   logic [CW-1:0]                  cnt;
   logic [N_WORDS-1:0][8+d-1:0]    state_buf;
   logic                           accept;

   // Each set r bit folds its B row into the data byte (GF(2) only).
   function automatic logic [7:0] decode_word(input logic [8+d-1:0] c,
                                              input logic [d-1:0][7:0] b);
      logic [7:0] y;
      y = c[7:0];
      for (int j = 0; j < d; j++)
         if (c[8+j]) y = y ^ b[j];
      return y;
   endfunction

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (accept)               nxt = BUSY;
         BUSY:    if (cnt == LAST)          nxt = DONE;
         DONE:    if (out_ready)            nxt = IDLE;
         default:                           nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Input buffer needs no reset: it is only read after a capture.
   always_ff @(posedge clk) begin
      if (accept) state_buf <= in_state;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         out_data <= '0;
         err      <= 1'b0;
      end else begin
         if (in_valid && !in_ready) err <= 1'b1;
         if (accept) cnt <= '0;
         else if (state == BUSY) begin
            out_data[cnt] <= decode_word(state_buf[cnt], B);
            cnt           <= (cnt == LAST) ? '0 : cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_clm_state_decoder.sv
// Directed + randomized bench for clm_state_decoder; expected bytes come from a
// bit-level parity model and from an encoder that masks known plaintext.
module tb_clm_state_decoder;

   localparam int D  = 4;
   localparam int NW = 16;
   localparam int W  = 8 + D;

   typedef logic [NW-1:0][W-1:0] st_t;
   typedef logic [NW-1:0][7:0]   pt_t;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   st_t                in_state;
   logic [D-1:0][7:0]  bm;
   logic               out_valid;
   logic               out_ready;
   pt_t                out_data;
   logic               err;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   clm_state_decoder #(.d(D), .N_WORDS(NW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_state(in_state), .B(bm), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Data bit i flips when an odd number of set r bits have column bit i set.
   function automatic pt_t model_decode(input st_t s, input logic [D-1:0][7:0] b);
      pt_t  y;
      logic [D-1:0] col;
      for (int k = 0; k < NW; k++)
         for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < D; j++) col[j] = b[j][i];
            y[k][i] = s[k][i] ^ (^(s[k][W-1:8] & col));
         end
      return y;
   endfunction

   function automatic logic [W-1:0] encode(input logic [7:0] p, input logic [D-1:0] r,
                                          input logic [D-1:0][7:0] b);
      logic [7:0] m;
      m = 8'h00;
      for (int j = 0; j < D; j++) m = m ^ (b[j] & {8{r[j]}});
      return {r, p ^ m};
   endfunction

   // Present one state, measure accept->out_valid latency, check data, finish handshake.
   task automatic run_state(input string tag, input st_t s, input bit early);
      int   lat;
      pt_t  exp;
      exp = model_decode(s, bm);
      check({tag, "_in_ready"}, in_ready, 1);
      in_state  = s;
      in_valid  = 1'b1;
      out_ready = early;
      step();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         step();
         lat++;
      end
      check({tag, "_latency"}, lat, NW);
      check({tag, "_data"}, out_data, exp);
      out_ready = 1'b1;
      step();
      check({tag, "_valid_drop"}, out_valid, 0);
      check({tag, "_ready_back"}, in_ready, 1);
      out_ready = 1'b0;
   endtask

   initial begin
      st_t  s;
      pt_t  pt, held;
      logic [D-1:0] r;
      int   lat, acc, prev_acc;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_state = '0; bm = '0;
      step(); step();
      rst = 1'b0;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_err", err, 0);

      // Zero refresh: mask must vanish whatever B is
      bm = $urandom;
      for (int k = 0; k < NW; k++) s[k] = {4'h0, 8'hA5};
      run_state("zero_r", s, 1'b0);
      check("zero_r_bytes", out_data, {NW{8'hA5}});

      // Single mask bit on word 3; out_ready held high before DONE
      bm = '0; bm[0][0] = 1'b1;
      s = '0; s[3][8] = 1'b1;
      run_state("single", s, 1'b1);
      check("single_w3", out_data[3], 8'h01);
      check("single_rest", out_data & ~(128'hFF << 24), 0);

      // Parity accumulation: r bits 0,1,2 set
      bm[0] = 8'hFF; bm[1] = 8'hFF; bm[2] = 8'h0F; bm[3] = 8'h00;
      for (int k = 0; k < NW; k++) s[k] = {4'b0111, 8'h00};
      run_state("parity", s, 1'b0);
      check("parity_bytes", out_data, {NW{8'h0F}});

      // Round trip, back-to-back, one state per NW+2 cycles
      bm = $urandom;
      out_ready = 1'b1;
      prev_acc = 0;
      for (int n = 0; n < 100; n++) begin
         for (int k = 0; k < NW; k++) begin
            pt[k] = 8'($urandom);
            r     = D'($urandom);
            s[k]  = encode(pt[k], r, bm);
         end
         in_state = s;
         in_valid = 1'b1;
         step();
         acc = cyc;
         in_valid = 1'b0;
         if (n > 0) check("rt_period", acc - prev_acc, NW + 2);
         prev_acc = acc;
         lat = 0;
         while (!out_valid && lat < 40) begin
            step();
            lat++;
         end
         check("rt_data", out_data, pt);
         step();
      end
      out_ready = 1'b0;
      check("rt_err", err, 0);

      // Backpressure with illegal input pulses in DONE
      bm = $urandom;
      for (int k = 0; k < NW; k++) s[k] = {4'($urandom), 8'($urandom)};
      in_state = s; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         step();
         lat++;
      end
      check("bp_latency", lat, NW);
      held = model_decode(s, bm);
      for (int c = 0; c < 10; c++) begin
         in_valid = c[0];
         in_state = ~s;
         step();
         check("bp_data", out_data, held);
         check("bp_in_ready", in_ready, 0);
         check("bp_out_valid", out_valid, 1);
      end
      in_valid = 1'b0;
      check("bp_err", err, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp_valid_drop", out_valid, 0);
      check("bp_ready_back", in_ready, 1);
      check("bp_err_sticky", err, 1);

      // Reset with counter at 7
      for (int k = 0; k < NW; k++) s[k] = {4'($urandom), 8'($urandom)};
      in_state = s; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int c = 0; c < 7; c++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_out_data", out_data, 0);
      check("mid_rst_err", err, 0);
      lat = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (out_valid) lat++;
      end
      check("mid_rst_no_pulse", lat, 0);
      for (int k = 0; k < NW; k++) s[k] = {4'($urandom), 8'($urandom)};
      run_state("post_rst", s, 1'b0);
      check("post_rst_err", err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
